// File: rtl/actv_relu_block.sv
// actv_relu_block: registered, lane-parallel ReLU activation stage.
// Each lane is clamped to zero when negative. Otherwise it is resized to
// OUTPUT_WIDTH, saturating when the output is narrower than the input.
module actv_relu_block #(
    parameter int INPUT_WIDTH  = 22,
    parameter int NUM_INPUTS   = 4,
    parameter int OUTPUT_WIDTH = INPUT_WIDTH
) (
    input  logic                                     actv_clk,
    input  logic                                     actv_rst_b,
    input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]   actv_in_i,
    output logic [NUM_INPUTS-1:0][OUTPUT_WIDTH-1:0]  actv_out_o
);

    // Common width that holds both the input magnitude and the output limit,
    // so the saturation compare works whichever side is wider.
    localparam int MAXW = (INPUT_WIDTH > OUTPUT_WIDTH) ? INPUT_WIDTH : OUTPUT_WIDTH;

    // Largest non-negative value representable in a signed OUTPUT_WIDTH lane.
    localparam logic [MAXW-1:0] OUT_LIMIT = MAXW'({1'b0, {(OUTPUT_WIDTH-1){1'b1}}});

    // Negative lanes give zero; non-negative lanes pass through, clipped to
    // OUT_LIMIT. When the output is at least as wide as the input the clip
    // can never trigger, so that case reduces to zero-extension.
    function automatic logic [OUTPUT_WIDTH-1:0] relu_sat(
        input logic signed [INPUT_WIDTH-1:0] v
    );
        logic [MAXW-1:0] mag;
        mag = MAXW'(unsigned'(v));
        if (v < 0) begin
            return '0;
        end else if (mag > OUT_LIMIT) begin
            return OUT_LIMIT[OUTPUT_WIDTH-1:0];
        end else begin
            return mag[OUTPUT_WIDTH-1:0];
        end
    endfunction

    logic [NUM_INPUTS-1:0][OUTPUT_WIDTH-1:0] relu_p0;

    // Stage p0: capture every lane's ReLU result each edge; async reset clears all lanes.
    always_ff @(posedge actv_clk or posedge actv_rst_b) begin
        if (actv_rst_b) begin
            relu_p0 <= '0;
        end else begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                relu_p0[k] <= relu_sat(signed'(actv_in_i[k]));
            end
        end
    end

    assign actv_out_o = relu_p0;

endmodule

// File: tb/tb_actv_relu_block.sv
// Self-checking bench for actv_relu_block: a default-width instance and a
// 16-bit narrow-output instance share clock, reset and input vector.
module tb_actv_relu_block;

    localparam int IW = 22;
    localparam int N  = 4;
    localparam int OW = 22;
    localparam int NW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N-1:0][IW-1:0] din = '0;
    logic [N-1:0][OW-1:0] dout_w;
    logic [N-1:0][NW-1:0] dout_n;

    int checks = 0;
    int errors = 0;

    actv_relu_block #(.INPUT_WIDTH(IW), .NUM_INPUTS(N), .OUTPUT_WIDTH(OW)) dut_w (
        .actv_clk   (clk),
        .actv_rst_b (rst),
        .actv_in_i  (din),
        .actv_out_o (dout_w)
    );

    actv_relu_block #(.INPUT_WIDTH(IW), .NUM_INPUTS(N), .OUTPUT_WIDTH(NW)) dut_n (
        .actv_clk   (clk),
        .actv_rst_b (rst),
        .actv_in_i  (din),
        .actv_out_o (dout_n)
    );

    always #5 clk = ~clk;

    // Reference: interpret each lane as a signed integer, apply max(0, v),
    // then clip to the largest positive value of a signed ow-bit number.
    function automatic longint relu_ref(input logic [IW-1:0] lane, input int ow);
        logic signed [IW-1:0] s;
        longint v;
        longint lim;
        s   = lane;
        v   = s;
        lim = (longint'(1) <<< (ow - 1)) - 1;
        if (v < 0) return 0;
        if (v > lim) return lim;
        return v;
    endfunction

    function automatic logic [N*OW-1:0] model_w(input logic [N-1:0][IW-1:0] v);
        logic [N-1:0][OW-1:0] r;
        for (int k = 0; k < N; k++) r[k] = OW'(relu_ref(v[k], OW));
        return r;
    endfunction

    function automatic logic [N*NW-1:0] model_n(input logic [N-1:0][IW-1:0] v);
        logic [N-1:0][NW-1:0] r;
        for (int k = 0; k < N; k++) r[k] = NW'(relu_ref(v[k], NW));
        return r;
    endfunction

    task automatic check_w(input string tag, input logic [N*OW-1:0] exp);
        checks++;
        assert (dout_w === exp) else begin
            errors++;
            $error("FAIL %s wide: observed=%h expected=%h", tag, dout_w, exp);
        end
    endtask

    task automatic check_n(input string tag, input logic [N*NW-1:0] exp);
        checks++;
        assert (dout_n === exp) else begin
            errors++;
            $error("FAIL %s narrow: observed=%h expected=%h", tag, dout_n, exp);
        end
    endtask

    // Apply a vector, let one rising edge capture it, and compare both
    // instances against the reference shortly after the edge.
    task automatic step(input string tag, input logic [N-1:0][IW-1:0] v);
        din = v;
        @(posedge clk);
        #1;
        check_w(tag, model_w(v));
        check_n(tag, model_n(v));
    endtask

    function automatic logic [N-1:0][IW-1:0] rand_vec();
        logic [N-1:0][IW-1:0] r;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 5))
                0:       r[k] = 22'h000000;
                1:       r[k] = 22'h1FFFFF;
                2:       r[k] = 22'h200000;
                3:       r[k] = IW'($urandom_range(0, 32767));
                default: r[k] = IW'($urandom);
            endcase
        end
        return r;
    endfunction

    initial begin
        logic [N-1:0][IW-1:0] v;

        // Asynchronous assertion before any clock edge has occurred.
        din = {22'h000123, 22'h1FFFFF, 22'h0ABCDE, 22'h000001};
        #2 rst = 1'b1;
        #1;
        check_w("rst_async_start", '0);
        check_n("rst_async_start", '0);

        // Reset held across several edges with changing inputs.
        for (int i = 0; i < 4; i++) begin
            din = rand_vec();
            @(posedge clk);
            #1;
            check_w("rst_held", '0);
            check_n("rst_held", '0);
        end

        // Release between edges; outputs stay zero until the next edge.
        @(negedge clk);
        rst = 1'b0;
        din = {22'h2FFFFF, 22'h1FFFFF, 22'h100000, 22'h200000};
        #1;
        check_w("post_release_no_edge", '0);
        @(posedge clk);
        #1;
        check_w("mixed", {22'h000000, 22'h1FFFFF, 22'h100000, 22'h000000});
        check_n("mixed", {16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000});

        // Boundary values.
        step("boundary", {22'h1FFFFF, 22'h000001, 22'h3FFFFF, 22'h000000});
        check_w("boundary_const", {22'h1FFFFF, 22'h000001, 22'h000000, 22'h000000});

        // Narrow-output saturation vector.
        step("narrow", {22'h200000, 22'h1FFFFF, 22'h008000, 22'h000100});
        check_n("narrow_const", {16'h0000, 16'h7FFF, 16'h7FFF, 16'h0100});

        // Streaming lane0 = 5, -3, 7, -1 on back-to-back edges.
        begin
            logic [IW-1:0] seq [4];
            logic [IW-1:0] exp0 [4];
            seq[0] = 22'd5;  seq[1] = 22'h3FFFFD; seq[2] = 22'd7;  seq[3] = 22'h3FFFFF;
            exp0[0] = 22'd5; exp0[1] = 22'd0;     exp0[2] = 22'd7; exp0[3] = 22'd0;
            for (int i = 0; i < 4; i++) begin
                v = rand_vec();
                v[0] = seq[i];
                step("stream", v);
                checks++;
                assert (dout_w[0] === exp0[i]) else begin
                    errors++;
                    $error("FAIL stream_lane0 observed=%h expected=%h", dout_w[0], exp0[i]);
                end
            end
        end

        // Randomized back-to-back vectors.
        for (int i = 0; i < 40; i++) begin
            step("random", rand_vec());
        end

        // Reset pulse mid-stream, entirely between two edges.
        for (int k = 0; k < N; k++) v[k] = IW'($urandom_range(1, 22'h1FFFFF));
        step("pre_mid_rst", v);
        for (int k = 0; k < N; k++) v[k] = IW'($urandom_range(1, 22'h1FFFFF));
        din = v;
        #1 rst = 1'b1;
        #1;
        check_w("mid_rst_async", '0);
        check_n("mid_rst_async", '0);
        #1 rst = 1'b0;
        #1;
        check_w("mid_rst_released", '0);
        @(posedge clk);
        #1;
        check_w("after_mid_rst", model_w(v));
        check_n("after_mid_rst", model_n(v));

        // A few more random cycles after recovery.
        for (int i = 0; i < 8; i++) begin
            step("random_post", rand_vec());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout reached before bench completed");
        $fatal(1, "timeout");
    end

endmodule
